search_genclk_div: RTL and testbench
====================================

Name: search_genclk_div

Overview:
- Programmable integer clock divider and data hand-off stage. It sits directly upstream of the divided-clock register domain.
- Produces a registered divided clock from `clk`, plus rise/fall strobes in the `clk` domain.
- Presents a data word that is launched on the divided clock's falling phase, so it is stable at the next divided rising edge.
- Replaces the fixed self-toggling divide-by-2 flop with a runtime-loadable ratio that changes glitch-free.

Parameters:
- CNT_W, 8, width of ratio and phase counter.
- DATA_W, 8, width of hand-off data.
- DIV_DEFAULT, 2, ratio after reset; must be >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run request for divided clock.
- div_ratio  in  CNT_W  requested ratio N; values 0 and 1 are treated as 2.
- ratio_load  in  1  one-cycle pulse; captures div_ratio as pending.
- ratio_ack  out  1  one-cycle pulse when the pending ratio becomes active.
- active_ratio  out  CNT_W  ratio currently in force (after clamp).
- data_in  in  DATA_W  word for divided domain.
- data_valid  in  1  captures data_in into hold register.
- div_clk  out  1  divided clock, registered, glitch-free.
- div_rise  out  1  high in the clk cycle where div_clk is 1 and was 0 the previous cycle.
- div_fall  out  1  high in the clk cycle where div_clk is 0 and was 1 the previous cycle.
- data_out  out  DATA_W  word launched to divided domain.
- data_out_valid  out  1  data_out holds fresh data for the current divided period.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset:
  - One clock, `clk`; reset `rst` is synchronous and active-high.
  - All state is registered on the rising edge of `clk`.
  - Reset values:
    - div_clk=0, div_rise=0, div_fall=0, ratio_ack=0, data_out=0, data_out_valid=0, busy=0.
    - active_ratio=DIV_DEFAULT; pending and hold registers empty; cnt=0; state=IDLE.
  - Reset asserted mid-operation forces all reset values on that edge; the current period is truncated.
- High phase: H = N - floor(N/2). Examples: N=4 gives H=2; N=3 gives H=2; N=2 gives H=1.
- FSM states IDLE, RUN, STOP:
  - IDLE:
    - div_clk=0.
    - On an edge with en=1: go to RUN, cnt<=0, div_clk<=1. The first rise is 1 cycle after en is sampled.
  - RUN:
    - cnt <= (cnt==N-1) ? 0 : cnt+1.
    - div_clk <= (next cnt < H).
    - en=0 sampled: go to STOP and keep counting.
  - STOP:
    - Continue counting.
    - At the wrap edge (cnt==N-1): go to IDLE, div_clk stays 0. No truncated high or low phase.
    - en=1 sampled in STOP: return to RUN with no change to cnt or div_clk.
- Ratio update:
  - ratio_load captures the clamped div_ratio into pending.
  - A later load before apply overwrites pending; only one ack is issued.
  - Pending is applied on the period-boundary edge (cnt wraps to 0, or the IDLE->RUN edge), and only if it was already pending before that edge.
  - A load coinciding with a boundary edge applies at the following boundary.
  - In IDLE with en=0, pending applies on the next edge.
  - ratio_ack pulses in the cycle after the apply edge; active_ratio updates on that same edge.
- Data hand-off:
  - data_valid loads the hold register (last write wins) and sets hold_full.
  - On the edge that drives div_clk 1->0: if hold_full, then data_out<=hold, data_out_valid<=1, and hold_full clears.
  - Otherwise on that edge data_out_valid<=0.
  - data_valid on the same edge as the fall transfer is held and launched at the next fall.
  - data_out changes only at fall edges, so it is stable for ≥ floor(N/2) clk cycles before each div_clk rise.
  - In IDLE, data_out and data_out_valid hold their values.

Decomposition:
- Package search_genclk_pkg holds:
  - the state enum (IDLE, RUN, STOP);
  - the clamp function (N<2 -> 2);
  - the high-phase function H(N).
- One sub-module, search_genclk_phase: counter, FSM and div_clk/strobe generation.
- The top level adds ratio pending/apply and the data hold/launch registers.

Test Plan:
- N=4, en=1 from cycle 0 -> div_clk 1,1,0,0 repeating from cycle 1; div_rise at cycles 1,5,9; div_fall at cycles 3,7.
- ratio_load with div_ratio=3 while running N=4 at cnt=1 -> current period completes; next period is 1,1,0; ratio_ack one cycle after the boundary; active_ratio=3.
- div_ratio=0 loaded in IDLE -> active_ratio=2 next cycle; div_clk alternates 1,0.
- en dropped while div_clk=1 at N=6 -> remaining 1s then 0s complete; busy falls at the wrap edge. Re-asserting en in STOP -> pattern continues without a gap.
- N=4: data_valid with 0xA5 at cycle 1 -> data_out=0xA5, data_out_valid=1 from the cycle-3 fall edge, stable across the cycle-5 rise. With no new data, valid=0 after the cycle-7 fall.
- rst pulsed mid-high phase -> div_clk=0, active_ratio=DIV_DEFAULT, data_out_valid=0 the next cycle; restarts per the IDLE rule.

Source files
------------

// File: rtl/search_genclk_pkg.sv
// Shared types and ratio helpers for the programmable clock divider.
package search_genclk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

    // Ratios below 2 cannot form a clock with both a high and a low phase.
    function automatic logic [31:0] clamp_ratio(input logic [31:0] n);
        return (n < 32'd2) ? 32'd2 : n;
    endfunction

    function automatic logic [31:0] high_phase(input logic [31:0] n);
        return n - (n >> 1);
    endfunction

endpackage

// File: rtl/search_genclk_phase.sv
// Phase counter and run/stop FSM producing the registered divided clock and its strobes.
module search_genclk_phase
    import search_genclk_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [CNT_W-1:0] ratio_i,
    output state_e           state_o,
    output logic             div_clk_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             boundary_o,
    output logic             fall_edge_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_clk_q, div_clk_d;
    logic             rise_q, fall_q;

    logic [CNT_W-1:0] high_n;
    logic [CNT_W-1:0] last_n;
    logic [CNT_W-1:0] cnt_inc;
    logic             wrap;

    assign high_n  = CNT_W'(high_phase(32'(ratio_i)));
    assign last_n  = ratio_i - CNT_W'(1);
    assign wrap    = (cnt_q == last_n);
    assign cnt_inc = wrap ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_clk_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_clk_q <= div_clk_d;
            rise_q    <= div_clk_d & ~div_clk_q;
            fall_q    <= ~div_clk_d & div_clk_q;
        end
    end

    // STOP keeps counting so the period in flight finishes; only its wrap may return to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                state_d = en_i ? RUN : IDLE;
            end
            RUN: begin
                cnt_d   = cnt_inc;
                state_d = en_i ? RUN : STOP;
            end
            STOP: begin
                cnt_d = cnt_inc;
                if (en_i) state_d = RUN;
                else if (wrap) state_d = IDLE;
                else state_d = STOP;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        div_clk_d = 1'b0;
        if (state_q == IDLE) div_clk_d = en_i;
        else if (state_d != IDLE) div_clk_d = (cnt_d < high_n);
        boundary_o  = (state_q == IDLE) | wrap;
        fall_edge_o = div_clk_q & ~div_clk_d;
    end

    assign state_o   = state_q;
    assign div_clk_o = div_clk_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;

endmodule

// File: rtl/search_genclk_div.sv
// Programmable clock divider with glitch-free ratio change and fall-launched data hand-off.
module search_genclk_div
    import search_genclk_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DATA_W      = 8,
    parameter int DIV_DEFAULT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CNT_W-1:0]  div_ratio,
    input  logic              ratio_load,
    output logic              ratio_ack,
    output logic [CNT_W-1:0]  active_ratio,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              div_clk,
    output logic              div_rise,
    output logic              div_fall,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    output logic              busy,
    output logic [1:0]        dbg_state_o
);

    localparam logic [CNT_W-1:0] RESET_RATIO = CNT_W'(clamp_ratio(32'(DIV_DEFAULT)));

    state_e            phase_state;
    logic              boundary, fall_edge, apply;

    logic [CNT_W-1:0]  active_q, active_d;
    logic [CNT_W-1:0]  pend_q, pend_d;
    logic              pend_full_q, pend_full_d;
    logic              ack_q;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dvalid_q, dvalid_d;

    search_genclk_phase #(.CNT_W(CNT_W)) u_phase (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en),
        .ratio_i     (active_q),
        .state_o     (phase_state),
        .div_clk_o   (div_clk),
        .rise_o      (div_rise),
        .fall_o      (div_fall),
        .boundary_o  (boundary),
        .fall_edge_o (fall_edge)
    );

    // Only a ratio pending before the boundary edge is applied; a load on that edge waits one period.
    assign apply = pend_full_q & boundary;

    always_comb begin
        active_d    = apply ? pend_q : active_q;
        pend_d      = ratio_load ? CNT_W'(clamp_ratio(32'(div_ratio))) : pend_q;
        pend_full_d = ratio_load | (pend_full_q & ~apply);
        hold_d      = data_valid ? data_in : hold_q;
        hold_full_d = data_valid | (hold_full_q & ~fall_edge);
        dout_d      = dout_q;
        dvalid_d    = dvalid_q;
        if (fall_edge) begin
            dvalid_d = hold_full_q;
            if (hold_full_q) dout_d = hold_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q    <= RESET_RATIO;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            ack_q       <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            dout_q      <= '0;
            dvalid_q    <= 1'b0;
        end else begin
            active_q    <= active_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            ack_q       <= apply;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            dout_q      <= dout_d;
            dvalid_q    <= dvalid_d;
        end
    end

    assign ratio_ack      = ack_q;
    assign active_ratio   = active_q;
    assign data_out       = dout_q;
    assign data_out_valid = dvalid_q;
    assign busy           = (phase_state != IDLE);
    assign dbg_state_o    = phase_state;

endmodule

// File: tb/tb_search_genclk_div.sv
// Randomized scoreboard bench for search_genclk_div against a period-level reference model.
module tb_search_genclk_div;

    localparam int CNT_W       = 8;
    localparam int DATA_W      = 8;
    localparam int DIV_DEFAULT = 2;

    logic              clk = 1'b0;
    logic              rst, en, ratio_load, data_valid;
    logic [CNT_W-1:0]  div_ratio;
    logic [DATA_W-1:0] data_in;
    logic              ratio_ack, div_clk, div_rise, div_fall, data_out_valid, busy;
    logic [CNT_W-1:0]  active_ratio;
    logic [DATA_W-1:0] data_out;
    logic [1:0]        dbg_state;

    search_genclk_div #(.CNT_W(CNT_W), .DATA_W(DATA_W), .DIV_DEFAULT(DIV_DEFAULT)) dut (
        .clk(clk), .rst(rst), .en(en), .div_ratio(div_ratio), .ratio_load(ratio_load),
        .ratio_ack(ratio_ack), .active_ratio(active_ratio), .data_in(data_in),
        .data_valid(data_valid), .div_clk(div_clk), .div_rise(div_rise), .div_fall(div_fall),
        .data_out(data_out), .data_out_valid(data_out_valid), .busy(busy), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              div_clk, rise, fall, ack, busy, dvalid;
        logic [CNT_W-1:0]  ratio;
        logic [DATA_W-1:0] dout;
    } exp_t;

    exp_t              cyc_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [CNT_W-1:0]  ack_q[$];
    int total = 0;
    int bad   = 0;

    // Reference model: position inside the current divided period plus run/stop intent.
    int m_busy, m_stop, m_pos, m_n, m_pend, m_pend_full;
    int m_hold, m_hold_full, m_dout, m_dvalid, m_clk, m_rise, m_fall, m_ack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit ld, input int rat,
                              input bit dv, input int din);
        int  n_pos, n_busy, n_stop, n_clk;
        bit  boundary, apply;
        if (r) begin
            m_busy = 0; m_stop = 0; m_pos = 0; m_n = DIV_DEFAULT; m_pend = 0; m_pend_full = 0;
            m_hold = 0; m_hold_full = 0; m_dout = 0; m_dvalid = 0; m_clk = 0;
            m_rise = 0; m_fall = 0; m_ack = 0;
            return;
        end
        boundary = (m_busy == 0) || (m_pos == m_n - 1);
        apply    = (m_pend_full != 0) && boundary;
        if (m_busy == 0) begin
            n_busy = e; n_stop = 0; n_pos = 0;
        end else begin
            n_pos  = (m_pos + 1) % m_n;
            n_busy = (m_stop != 0 && !e && m_pos == m_n - 1) ? 0 : 1;
            n_stop = !e;
        end
        n_clk  = (n_busy != 0) ? int'(n_pos < m_n - m_n / 2) : 0;
        m_rise = (n_clk != 0 && m_clk == 0);
        m_fall = (n_clk == 0 && m_clk != 0);
        if (m_fall != 0) begin
            if (m_hold_full != 0) begin
                m_dout = m_hold; m_dvalid = 1; m_hold_full = 0;
                exp_q.push_back(DATA_W'(m_hold));
            end else begin
                m_dvalid = 0;
            end
        end
        if (dv) begin
            m_hold = din; m_hold_full = 1;
        end
        m_ack = apply;
        if (apply) begin
            m_n = m_pend;
            ack_q.push_back(CNT_W'(m_n));
        end
        m_pend_full = ld || (m_pend_full != 0 && !apply);
        if (ld) m_pend = (rat < 2) ? 2 : rat;
        m_busy = n_busy; m_stop = n_stop; m_pos = n_pos; m_clk = n_clk;
    endtask

    task automatic drive(input bit r, input bit e, input bit ld, input int rat,
                         input bit dv, input int din);
        exp_t x;
        rst = r; en = e; ratio_load = ld; div_ratio = CNT_W'(rat);
        data_valid = dv; data_in = DATA_W'(din);
        model_step(r, e, ld, rat, dv, din);
        x.div_clk = 1'(m_clk); x.rise = 1'(m_rise); x.fall = 1'(m_fall); x.ack = 1'(m_ack);
        x.busy = 1'(m_busy); x.dvalid = 1'(m_dvalid);
        x.ratio = CNT_W'(m_n); x.dout = DATA_W'(m_dout);
        cyc_q.push_back(x);
        @(negedge clk);
    endtask

    // Monitor: per-cycle outputs, plus launched words and ratio acks as they are presented.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            check("div_clk", div_clk, e.div_clk);
            check("div_rise", div_rise, e.rise);
            check("div_fall", div_fall, e.fall);
            check("ratio_ack", ratio_ack, e.ack);
            check("busy", busy, e.busy);
            check("data_out_valid", data_out_valid, e.dvalid);
            check("active_ratio", active_ratio, e.ratio);
            check("data_out", data_out, e.dout);
        end
        if (div_fall && data_out_valid) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL launch at %0t: got word %0h expected no launch", $time, data_out);
            end else begin
                check("launch_word", data_out, exp_q.pop_front());
            end
        end
        if (ratio_ack) begin
            if (ack_q.size() == 0) begin
                total++; bad++;
                $display("FAIL ack at %0t: got ack ratio %0d expected no ack", $time, active_ratio);
            end else begin
                check("ack_ratio", active_ratio, ack_q.pop_front());
            end
        end
    end

    initial begin
        int e_r;
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 4, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 1, 8'hA5);
        for (int i = 0; i < 10; i++) drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 3, 0, 0);
        for (int i = 0; i < 10; i++) drive(0, 1, 0, 0, (i == 4), 8'h3C);
        drive(0, 1, 1, 6, 0, 0);
        for (int i = 0; i < 9; i++) drive(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) drive(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) drive(0, 1, 0, 0, (i == 1), 8'h5A);
        drive(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) drive(0, 1, 0, 0, 0, 0);
        e_r = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) e_r = !e_r;
            drive($urandom_range(0, 599) == 0, 1'(e_r), $urandom_range(0, 24) == 0,
                  int'($urandom_range(0, 9)), $urandom_range(0, 5) == 0,
                  int'($urandom_range(0, 255)));
        end
        repeat (2) @(negedge clk);
        check("cycle_queue_drained", cyc_q.size(), 0);
        check("launch_queue_drained", exp_q.size(), 0);
        check("ack_queue_drained", ack_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
